prog_loader: RTL
================

# prog_loader

Program-memory writer for the rv32e SoC. It accepts a framed byte stream over a valid/ready byte interface, assembles little-endian 32-bit instruction words and writes them into the program RAM that the core fetches from via `program_addr_bus`/`program_data_bus`. While a load is in progress it holds the core in reset, and it releases the core only after a checksum-verified frame.

## Interface

Parameters:
- `ADDR_WIDTH`, default 8: word-address width of the program RAM. Capacity is 2^ADDR_WIDTH words.
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written.

Ports:
- `clk`, input, 1: the single clock. All logic is rising-edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_data`, input, 8: stream byte.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: the block can accept a byte. A byte transfers on a rising edge where `in_valid && in_ready`.
- `mem_we`, output, 1: program RAM write strobe, one cycle per word.
- `mem_addr`, output, 32: byte address of the write, always word-aligned.
- `mem_wdata`, output, 32: write data.
- `cpu_hold`, output, 1: 1 holds the core in reset.
- `done`, output, 1: last load completed with a good checksum.
- `error`, output, 1: last frame was rejected.

## Operation

- Frame format: sync `0xA5`, `N_lo`, `N_hi`, then 4·N data bytes, then checksum byte.
  - N is a 16-bit word count.
  - Data is little-endian per word: the first byte goes to [7:0].
  - Checksum is the sum of all data bytes modulo 256. Sync and length bytes are excluded.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE.
  - IDLE: bytes other than `0xA5` are accepted and discarded. Accepting `0xA5` goes to LEN_LO, clears `done` and `error`, and sets `cpu_hold=1`.
  - LEN_LO: latch `N[7:0]`, go to LEN_HI.
  - LEN_HI: latch `N[15:8]`.
    - If N > 2^ADDR_WIDTH: `error=1`, go to IDLE. No writes occur.
    - If N = 0: go to CSUM.
    - Otherwise: go to DATA. Word index k=0, running sum=0.
  - DATA: shift each byte into the word and add it to the sum. When the 4th byte of a word is accepted, go to WRITE.
  - WRITE (one cycle): `mem_we=1`, `mem_addr = BASE_ADDR + 4·k`, `mem_wdata` = the assembled word. Then k++. If k = N after the increment, go to CSUM; otherwise go to DATA.
  - CSUM: accept one byte.
    - Equal to the sum: `done=1`, `cpu_hold=0`, go to DONE.
    - Otherwise: `error=1`, `cpu_hold` stays 1, go to IDLE.
  - DONE: bytes other than `0xA5` are discarded. `0xA5` behaves as in IDLE, so the core can be reloaded.
- `in_ready`:
  - 1 in every state except WRITE.
  - 0 in WRITE.
  - 0 while `reset` is high.
- `done` and `error` are sticky. They are cleared only by an accepted sync byte or by reset.
- `cpu_hold` is 1 from reset until the first good frame. It returns to 1 for every new frame.
- Address arithmetic is 32-bit and wraps modulo 2^32. The per-word byte counter is 2 bits. The sum is 8 bits and wraps.

## Timing

- Reset values:
  - `cpu_hold=1`.
  - `done=0`, `error=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
  - `in_ready=0` while `reset` is asserted; state IDLE, so `in_ready=1` on the first cycle after release.
- Write latency: `mem_we` rises in the cycle immediately after the edge that accepts the 4th byte of a word.
  - The strobe lasts exactly one cycle.
  - `mem_addr` and `mem_wdata` are registered and hold their values until the next write.
- Throughput: at most 4 bytes per 5 cycles in DATA, because of the WRITE bubble.
- `in_valid` may drop at any time. Gaps never alter state, sum or partial word.
- Checksum decision: `done`/`error`/`cpu_hold` change on the edge that accepts the checksum byte and are visible the next cycle.
- Length rejection: `error` is set on the edge that accepts `N_hi`.
- Reset mid-frame: all outputs go to their reset values on the next edge and the partial word is discarded. Words already written stay in RAM.
- `0xA5` bytes in LEN_*, DATA or CSUM are data, not resync.

## Test plan

- **Good frame.** `A5 02 00 13 05 10 00 93 05 20 00 E0`, `in_valid` held high.
  - Write 1: `mem_addr=0`, `mem_wdata=0x00100513`.
  - Write 2: `mem_addr=4`, `mem_wdata=0x00200593`.
  - Each `mem_we` is 1 cycle, with `in_ready=0` during it.
  - Then `done=1`, `cpu_hold=0`.
- **Bad checksum.** Same frame with final byte `E1`.
  - Both writes still occur.
  - `error=1`, `done=0`, `cpu_hold=1`, state IDLE.
  - A subsequent good frame sets `done=1` and clears `error`.
- **Leading garbage and stalls.** `00 FF 5A`, then the good frame, with `in_valid` low on random cycles.
  - Writes and addresses are identical to the good-frame case.
  - No `mem_we` occurs before the sync byte.
- **Empty program.** `A5 00 00 00`: no `mem_we`, `done=1`, `cpu_hold=0`.
  - `A5 00 00 01` instead: `error=1`.
- **Oversize.** With ADDR_WIDTH=8, `A5 01 01`:
  - `error=1` the cycle after `N_hi`.
  - No writes.
  - The next sync byte is accepted normally.
- **Reset mid-DATA.** Assert `reset` after 6 data bytes.
  - All outputs return to their reset values.
  - A following full good frame with BASE_ADDR=0x100 writes to 0x100 and 0x104.

Source files
------------

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader that fills program RAM and gates the core
//
// Accepts frames of the form A5, N_lo, N_hi, 4*N data bytes, checksum, and
// writes the little-endian words to program RAM at BASE_ADDR + 4*k.
// The core is held in reset until a frame passes its checksum.
//
// Ports:
//   clk, reset           - rising-edge clock, synchronous active-high reset
//   in_data/in_valid     - byte stream input
//   in_ready             - byte can be accepted (low in WRITE and during reset)
//   mem_we               - one-cycle program RAM write strobe
//   mem_addr, mem_wdata  - registered write byte address / data
//   cpu_hold             - holds the core in reset
//   done, error          - sticky frame status
module prog_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CSUM,
        DONE
    } state_t;

    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;
    localparam logic [7:0]  SYNC     = 8'hA5;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] len_q;
    logic [16:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [7:0]  sum;
    logic [31:0] word_sr;
    logic [31:0] next_addr;

    logic        accept;
    logic [15:0] len_full;
    logic        oversize;
    logic        last_word;

    assign in_ready  = !reset && (state_q != WRITE);
    assign mem_we    = (state_q == WRITE);
    assign accept    = in_valid && in_ready;
    // Length as it will be once the byte currently offered in LEN_HI is taken.
    assign len_full  = {in_data, len_q[7:0]};
    assign oversize  = {17'd0, len_full} > CAPACITY;
    assign last_word = (word_cnt + 17'd1) == {1'b0, len_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept && in_data == SYNC) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (accept) state_d = LEN_HI;
            end
            LEN_HI: begin
                if (accept) begin
                    if (oversize)             state_d = IDLE;
                    else if (len_full == '0)  state_d = CSUM;
                    else                      state_d = DATA;
                end
            end
            DATA: begin
                if (accept && byte_cnt == 2'd3) state_d = WRITE;
            end
            WRITE: begin
                state_d = last_word ? CSUM : DATA;
            end
            CSUM: begin
                if (accept) state_d = (in_data == sum) ? DONE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q     <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            sum       <= '0;
            word_sr   <= '0;
            next_addr <= BASE_ADDR;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept && in_data == SYNC) begin
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                LEN_LO: begin
                    if (accept) len_q[7:0] <= in_data;
                end
                LEN_HI: begin
                    if (accept) begin
                        len_q[15:8] <= in_data;
                        word_cnt    <= '0;
                        byte_cnt    <= '0;
                        sum         <= '0;
                        next_addr   <= BASE_ADDR;
                        if (oversize) error <= 1'b1;
                    end
                end
                DATA: begin
                    if (accept) begin
                        // Shift in from the top so the first byte ends up in [7:0].
                        word_sr  <= {in_data, word_sr[31:8]};
                        sum      <= sum + in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_wdata <= {in_data, word_sr[31:8]};
                            mem_addr  <= next_addr;
                            next_addr <= next_addr + 32'd4;
                        end
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + 17'd1;
                end
                CSUM: begin
                    if (accept) begin
                        if (in_data == sum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            error    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
